median_border_fix: RTL and testbench

Output stage placed directly after the 5x5 median line buffer. It tracks column and row position from the delayed dv/hs/vs stream and learns the active-frame geometry. It replaces pixels whose 5x5 kernel falls outside the image, where the median output is not valid, with either the unfiltered centre pixel or a fixed fill colour. The result is a registered, timing-aligned RGB stream for the HDMI transmitter.

---
 rtl/median_border_fix.sv | 177 +++++++++++++++++
 tb/tb_median_border_fix.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/median_border_fix.sv
// median_border_fix
// Output stage behind the 5x5 median line buffer. It tracks the column and
// row of each pixel in the delayed dv/hs/vs stream and learns the active
// frame geometry at each vsync rising edge. Pixels whose kernel reaches
// outside the image are replaced with either the unfiltered centre pixel or
// a fixed fill colour. The result is a registered, aligned RGB stream for
// the HDMI transmitter.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-low reset
//   in_dv, in_hs, in_vs      incoming sync, aligned with the pixel buses
//   in_*_med                 median-filtered pixel
//   in_*_raw                 unfiltered kernel-centre pixel
//   mode                     0: border takes raw, 1: border takes FILL_RGB
//   tx_dv, tx_hs, tx_vs      sync delayed by one cycle
//   tx_red/green/blue        selected output pixel (0 outside active video)
//   frame_width/height       learned active geometry
//   geom_valid               a full frame has been measured since reset
//   geom_err                 line-length mismatch seen in the current frame
module median_border_fix #(
  parameter int unsigned BORDER   = 2,
  parameter int unsigned CNT_W    = 12,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_dv,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic [7:0]       in_red_med,
  input  logic [7:0]       in_green_med,
  input  logic [7:0]       in_blue_med,
  input  logic [7:0]       in_red_raw,
  input  logic [7:0]       in_green_raw,
  input  logic [7:0]       in_blue_raw,
  input  logic             mode,
  output logic             tx_dv,
  output logic             tx_hs,
  output logic             tx_vs,
  output logic [7:0]       tx_red,
  output logic [7:0]       tx_green,
  output logic [7:0]       tx_blue,
  output logic [CNT_W-1:0] frame_width,
  output logic [CNT_W-1:0] frame_height,
  output logic             geom_valid,
  output logic             geom_err
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] BorderW    = CNT_W'(BORDER);
  localparam logic [CNT_W:0]   DblBorderW = (CNT_W+1)'(2 * BORDER);

  logic             dvPrev_q, vsPrev_q;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] lastLen_q, lastLen_d;
  logic [CNT_W-1:0] frameWidth_q, frameWidth_d;
  logic [CNT_W-1:0] frameHeight_q, frameHeight_d;
  logic             geomValid_q, geomValid_d;
  logic             geomErr_q, geomErr_d;
  logic             txDv_q, txHs_q, txVs_q;
  logic [23:0]      txRgb_q, txRgb_d;

  logic             dvFall, vsRise, degenerate, isBorder;
  logic [23:0]      medRgb, rawRgb;

  assign medRgb = {in_red_med, in_green_med, in_blue_med};
  assign rawRgb = {in_red_raw, in_green_raw, in_blue_raw};

  // Position tracking and geometry learning. col_q holds the index of the
  // pixel currently on the inputs, so at the dv falling edge it equals the
  // length of the line just finished. The line-end update is applied before
  // the frame-end update so a coincident dv fall and vs rise still counts
  // the last line in the latched height.
  always_comb begin
    dvFall        = dvPrev_q & ~in_dv;
    vsRise        = in_vs & ~vsPrev_q;
    col_d         = '0;
    row_d         = row_q;
    lastLen_d     = lastLen_q;
    frameWidth_d  = frameWidth_q;
    frameHeight_d = frameHeight_q;
    geomValid_d   = geomValid_q;
    geomErr_d     = geomErr_q;

    if (in_dv) begin
      col_d = (col_q == CntMax) ? col_q : col_q + CntOne;
    end

    if (dvFall) begin
      row_d     = (row_q == CntMax) ? row_q : row_q + CntOne;
      lastLen_d = col_q;
      if (geomValid_q && (col_q != frameWidth_q)) begin
        geomErr_d = 1'b1;
      end
    end

    if (vsRise && (row_d != '0)) begin
      frameHeight_d = row_d;
      frameWidth_d  = lastLen_d;
      geomValid_d   = 1'b1;
      geomErr_d     = 1'b0;
      row_d         = '0;
    end
  end

  // Border classification of the current pixel against the learned geometry.
  // The degenerate test guards the subtractions below against underflow.
  always_comb begin
    degenerate = ({1'b0, frameWidth_q} <= DblBorderW) ||
                 ({1'b0, frameHeight_q} <= DblBorderW);
    isBorder   = degenerate ||
                 (col_q < BorderW) || (col_q >= frameWidth_q - BorderW) ||
                 (row_q < BorderW) || (row_q >= frameHeight_q - BorderW);
  end

  // Pixel select: blank outside active video, raw until geometry is known,
  // raw or fill on the border, median elsewhere.
  always_comb begin
    txRgb_d = '0;
    if (in_dv) begin
      if (!geomValid_q) begin
        txRgb_d = rawRgb;
      end else if (isBorder) begin
        txRgb_d = mode ? FILL_RGB : rawRgb;
      end else begin
        txRgb_d = medRgb;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvPrev_q      <= 1'b0;
      vsPrev_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      lastLen_q     <= '0;
      frameWidth_q  <= '0;
      frameHeight_q <= '0;
      geomValid_q   <= 1'b0;
      geomErr_q     <= 1'b0;
      txDv_q        <= 1'b0;
      txHs_q        <= 1'b0;
      txVs_q        <= 1'b0;
      txRgb_q       <= '0;
    end else begin
      dvPrev_q      <= in_dv;
      vsPrev_q      <= in_vs;
      col_q         <= col_d;
      row_q         <= row_d;
      lastLen_q     <= lastLen_d;
      frameWidth_q  <= frameWidth_d;
      frameHeight_q <= frameHeight_d;
      geomValid_q   <= geomValid_d;
      geomErr_q     <= geomErr_d;
      txDv_q        <= in_dv;
      txHs_q        <= in_hs;
      txVs_q        <= in_vs;
      txRgb_q       <= txRgb_d;
    end
  end

  assign tx_dv        = txDv_q;
  assign tx_hs        = txHs_q;
  assign tx_vs        = txVs_q;
  assign tx_red       = txRgb_q[23:16];
  assign tx_green     = txRgb_q[15:8];
  assign tx_blue      = txRgb_q[7:0];
  assign frame_width  = frameWidth_q;
  assign frame_height = frameHeight_q;
  assign geom_valid   = geomValid_q;
  assign geom_err     = geomErr_q;

endmodule

// File: tb/tb_median_border_fix.sv
// tb_median_border_fix
// Directed bench for median_border_fix: drives whole frames pixel by pixel,
// predicts every output pixel from its row/column and the geometry learned
// so far, and checks the learned geometry, the line-length error flag and
// the asynchronous reset.
module tb_median_border_fix;

  localparam logic [23:0] Fill = 24'h102030;
  localparam logic [23:0] Med  = 24'hAAAAAA;
  localparam logic [23:0] Raw  = 24'h555555;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inDv = 1'b0, inHs = 1'b0, inVs = 1'b0, inMode = 1'b0;
  logic [23:0] medPix = Med, rawPix = Raw;
  logic        txDv, txHs, txVs;
  logic [7:0]  txRed, txGreen, txBlue;
  logic [11:0] frameWidth, frameHeight;
  logic        geomValid, geomErr;

  logic [2:0]  prevSync = 3'b000;
  logic [23:0] prevRgb  = 24'h0;
  int          checks   = 0;
  int          errors   = 0;

  median_border_fix #(
    .BORDER  (2),
    .CNT_W   (12),
    .FILL_RGB(Fill)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_dv       (inDv),
    .in_hs       (inHs),
    .in_vs       (inVs),
    .in_red_med  (medPix[23:16]),
    .in_green_med(medPix[15:8]),
    .in_blue_med (medPix[7:0]),
    .in_red_raw  (rawPix[23:16]),
    .in_green_raw(rawPix[15:8]),
    .in_blue_raw (rawPix[7:0]),
    .mode        (inMode),
    .tx_dv       (txDv),
    .tx_hs       (txHs),
    .tx_vs       (txVs),
    .tx_red      (txRed),
    .tx_green    (txGreen),
    .tx_blue     (txBlue),
    .frame_width (frameWidth),
    .frame_height(frameHeight),
    .geom_valid  (geomValid),
    .geom_err    (geomErr)
  );

  // 100 MHz pixel clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: check what the DUT registered from the previous cycle's
  // inputs, then drive this cycle's inputs and remember their expected image.
  task automatic applyStimulus(input logic dv, input logic hs, input logic vs,
                               input logic [23:0] expRgb);
    @(posedge clk);
    #1;
    checkOutput("tx_sync", {29'd0, txDv, txHs, txVs}, {29'd0, prevSync});
    checkOutput("tx_rgb", {8'd0, txRed, txGreen, txBlue}, {8'd0, prevRgb});
    inDv     = dv;
    inHs     = hs;
    inVs     = vs;
    prevSync = {dv, hs, vs};
    prevRgb  = expRgb;
  endtask

  // Sends a w x h frame followed by a vsync pulse. Row badRow is one pixel
  // short. gv/fw/fh describe the geometry the DUT holds during this frame.
  task automatic sendFrame(input int w, input int h, input int badRow,
                           input logic m, input logic gv,
                           input int fw, input int fh);
    logic [23:0] expRgb;
    logic        errExp;
    logic        border;
    int          len;
    errExp = 1'b0;
    inMode = m;
    for (int r = 0; r < h; r++) begin
      len = (r == badRow) ? w - 1 : w;
      for (int c = 0; c < len; c++) begin
        border = (fw <= 4) || (fh <= 4) || (c < 2) || (c >= fw - 2) ||
                 (r < 2) || (r >= fh - 2);
        if (!gv)         expRgb = rawPix;
        else if (border) expRgb = m ? Fill : rawPix;
        else             expRgb = medPix;
        applyStimulus(1'b1, 1'b0, 1'b0, expRgb);
      end
      if (gv && (len != fw)) errExp = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
      checkOutput("geom_err_line", {31'd0, geomErr}, {31'd0, errExp});
      checkOutput("frame_width_hold", {20'd0, frameWidth}, 32'(fw));
      applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic checkGeometry(input string tag, input int fw, input int fh,
                               input logic gv, input logic err);
    checkOutput({tag, "_width"}, {20'd0, frameWidth}, 32'(fw));
    checkOutput({tag, "_height"}, {20'd0, frameHeight}, 32'(fh));
    checkOutput({tag, "_valid"}, {31'd0, geomValid}, {31'd0, gv});
    checkOutput({tag, "_err"}, {31'd0, geomErr}, {31'd0, err});
  endtask

  initial begin
    // Reset acts without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    checkOutput("reset_tx", {5'd0, txDv, txHs, txVs, txRed, txGreen, txBlue}, 32'd0);
    checkGeometry("reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // First frame: unmeasured, everything raw.
    sendFrame(16, 8, -1, 1'b0, 1'b0, 0, 0);
    checkGeometry("frame1", 16, 8, 1'b1, 1'b0);

    // Border pixels raw, interior median.
    sendFrame(16, 8, -1, 1'b0, 1'b1, 16, 8);
    checkGeometry("frame2", 16, 8, 1'b1, 1'b0);

    // Border pixels take the fill colour.
    sendFrame(16, 8, -1, 1'b1, 1'b1, 16, 8);
    checkGeometry("frame3", 16, 8, 1'b1, 1'b0);

    // One 15-pixel line; error clears at the next vsync.
    sendFrame(16, 8, 3, 1'b0, 1'b1, 16, 8);
    checkGeometry("frame4", 16, 8, 1'b1, 1'b0);

    // 4x4 frame judged against the old 16x8 geometry, then learned.
    sendFrame(4, 4, -1, 1'b0, 1'b1, 16, 8);
    checkGeometry("frame5", 4, 4, 1'b1, 1'b0);

    // Degenerate geometry: every pixel is border.
    sendFrame(4, 4, -1, 1'b0, 1'b1, 4, 4);
    checkGeometry("frame6", 4, 4, 1'b1, 1'b0);
    sendFrame(4, 4, -1, 1'b1, 1'b1, 4, 4);
    checkGeometry("frame7", 4, 4, 1'b1, 1'b0);

    // Reset in the middle of a line.
    inMode = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, rawPix);
    applyStimulus(1'b1, 1'b0, 1'b0, rawPix);
    applyStimulus(1'b1, 1'b0, 1'b0, rawPix);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midreset_tx", {5'd0, txDv, txHs, txVs, txRed, txGreen, txBlue}, 32'd0);
    checkGeometry("midreset", 0, 0, 1'b0, 1'b0);
    inDv = 1'b0;
    inHs = 1'b0;
    inVs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    prevSync = 3'b000;
    prevRgb  = 24'h0;

    // A vsync with no active lines leaves geometry unmeasured.
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkGeometry("emptyvs", 0, 0, 1'b0, 1'b0);

    // Raw passthrough until a full frame completes.
    sendFrame(4, 4, -1, 1'b1, 1'b0, 0, 0);
    checkGeometry("frame8", 4, 4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
